// File: rtl/res_drain.sv
// res_drain: streams GEMV result BRAM entries out as rounded, optionally ReLU'd, saturated int8 values.
package accelerator_config_pkg;
  localparam int MAX_ROWS = 16;
endpackage

module res_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = accelerator_config_pkg::MAX_ROWS,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int OUT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic [4:0]            shift,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic signed [DATA_WIDTH:0] QMAX = (DATA_WIDTH+1)'(2**(OUT_WIDTH-1)-1);
  localparam logic signed [DATA_WIDTH:0] QMIN = ~QMAX;
  state_t state;
  logic [ADDR_WIDTH:0] rows_q, issued, rows_in;
  logic [4:0] sh_q;
  logic relu_q, cap, cap_last, wp, rp, pop, issue;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic [1:0] cnt;
  logic [OUT_WIDTH-1:0] f_data [2];
  logic [ADDR_WIDTH-1:0] f_idx [2];
  logic f_last [2];
  logic signed [DATA_WIDTH:0] ext, bias, rnd, v;
  logic [OUT_WIDTH-1:0] q;
  assign rd_en = issue;
  assign rd_addr = issued[ADDR_WIDTH-1:0];
  assign out_valid = cnt != '0;
  assign out_data = f_data[rp];
  assign out_index = f_idx[rp];
  assign out_last = f_last[rp];
  // Issue counts the same-cycle pop so a full-rate stream never stalls on the 2-entry buffer.
  always_comb begin
    rows_in = (num_rows > (ADDR_WIDTH+1)'(DEPTH)) ? (ADDR_WIDTH+1)'(DEPTH) : num_rows;
    pop = out_valid & out_ready;
    issue = state == RUN && issued < rows_q && 3'(cnt) + 3'(cap) < 3'd2 + 3'(pop);
    ext = {rd_data[DATA_WIDTH-1], rd_data};
    bias = (sh_q == '0) ? '0 : (DATA_WIDTH+1)'(1) << (sh_q - 5'd1);
    rnd = (ext + bias) >>> sh_q;
    v = (relu_q && rnd[DATA_WIDTH]) ? '0 : rnd;
    q = v > QMAX ? QMAX[OUT_WIDTH-1:0] : v < QMIN ? QMIN[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rows_q <= '0;
      sh_q <= '0;
      relu_q <= 1'b0;
      issued <= '0;
      cap <= 1'b0;
      cap_idx <= '0;
      cap_last <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= '0;
      for (int i = 0; i < 2; i++) begin
        f_data[i] <= '0;
        f_idx[i] <= '0;
        f_last[i] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          rows_q <= rows_in;
          sh_q <= shift;
          relu_q <= relu_en;
          issued <= '0;
          busy <= 1'b1;
          done <= rows_in == '0;
          state <= rows_in == '0 ? FIN : RUN;
        end
        RUN: if (pop && out_last) begin
          state <= FIN;
          done <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
      if (issue) issued <= issued + 1'b1;
      cap <= issue;
      cap_idx <= rd_addr;
      cap_last <= issued == rows_q - 1'b1;
      if (cap) begin
        f_data[wp] <= q;
        f_idx[wp] <= cap_idx;
        f_last[wp] <= cap_last;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(cap) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_res_drain.sv
// tb_res_drain: directed checks of res_drain against hand-computed streams and cycle timing.
module tb_res_drain;
  localparam int DW = 32, D = 16, AW = 4, OW = 8;
  logic clk = 0, rst = 1, start = 0, relu_en = 0, out_ready = 0;
  logic [AW:0] num_rows = '0;
  logic [4:0] shift = '0;
  logic [DW-1:0] rd_data = '0;
  logic busy, done, rd_en, out_valid, out_last;
  logic [AW-1:0] rd_addr, out_index;
  logic [OW-1:0] out_data;
  logic [DW-1:0] bram [D];
  int npass = 0, nchk = 0;
  int hs_d[$], hs_i[$], hs_l[$], hs_c[$];
  int done_cyc, rd_cnt, last_addr, max_out, stall_bad, busy_bad, dseen;
  int e[$];

  res_drain dut (
    .clk(clk), .rst(rst), .start(start), .num_rows(num_rows), .shift(shift), .relu_en(relu_en),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= bram[rd_addr];

  task automatic check(input string tag, input longint got, input longint exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic drain(input int n, input int sh, input bit relu, input bit bp);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit pv = 0;
    logic [OW-1:0] pd = '0;
    logic [AW-1:0] pi = '0;
    logic pl = 0;
    hs_d.delete(); hs_i.delete(); hs_l.delete(); hs_c.delete();
    done_cyc = -1; rd_cnt = 0; last_addr = -1; max_out = 0; stall_bad = 0; busy_bad = 0;
    @(posedge clk); #1;
    start = 1; num_rows = 5'(n); shift = 5'(sh); relu_en = relu; out_ready = 1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start = 0;
      out_ready = bp ? pat[c % 4] : 1'b1;
      @(negedge clk);
      if (rd_cnt - hs_d.size() > max_out) max_out = rd_cnt - hs_d.size();
      if (!busy) busy_bad++;
      if (pv && !(out_valid && out_data == pd && out_index == pi && out_last == pl)) stall_bad++;
      pv = out_valid && !out_ready; pd = out_data; pi = out_index; pl = out_last;
      if (rd_en) begin rd_cnt++; last_addr = rd_addr; end
      if (out_valid && out_ready) begin
        hs_d.push_back($signed(out_data)); hs_i.push_back(out_index);
        hs_l.push_back(out_last); hs_c.push_back(c);
      end
      if (done) begin done_cyc = c; break; end
    end
  endtask

  task automatic check_out(input string tag);
    check({tag, "_count"}, hs_d.size(), e.size());
    for (int i = 0; i < e.size() && i < hs_d.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), hs_d[i], e[i]);
      check($sformatf("%s_idx%0d", tag, i), hs_i[i], i);
      check($sformatf("%s_last%0d", tag, i), hs_l[i], i == e.size() - 1);
    end
    check({tag, "_busy"}, busy_bad, 0);
  endtask

  initial begin
    #1 rst = 0;
    #20;
    check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0); check("rst_valid", out_valid, 0); check("rst_data", out_data, 0);
    check("rst_index", out_index, 0); check("rst_last", out_last, 0);
    @(negedge clk) rst = 1;

    for (int i = 0; i < D; i++) bram[i] = i;
    drain(8, 0, 0, 0);
    e = '{0, 1, 2, 3, 4, 5, 6, 7};
    check_out("basic");
    check("basic_first_cyc", hs_c.size() > 0 ? hs_c[0] : -1, 3);
    check("basic_last_cyc", hs_c.size() > 7 ? hs_c[7] : -1, 10);
    check("basic_done_cyc", done_cyc, 11);

    bram[0] = 5; bram[1] = -5; bram[2] = 1000; bram[3] = -1000; bram[4] = 6;
    drain(5, 1, 0, 0);
    e = '{3, -2, 127, -128, 3};
    check_out("round");
    check("round_done_cyc", done_cyc, 8);

    bram[0] = -3; bram[1] = 4;
    drain(2, 0, 1, 0);
    e = '{0, 4};
    check_out("relu");
    drain(2, 0, 0, 0);
    e = '{-3, 4};
    check_out("norelu");

    bram[0] = 32'h7fffffff; bram[1] = 32'h80000000;
    drain(2, 31, 0, 0);
    e = '{1, -1};
    check_out("shift31");

    e.delete();
    for (int i = 0; i < D; i++) begin bram[i] = 3 * i - 20; e.push_back(3 * i - 20); end
    drain(16, 0, 0, 1);
    check_out("bp");
    check("bp_stall_stable", stall_bad, 0);
    check("bp_outstanding_le2", max_out <= 2, 1);
    check("bp_done_seen", done_cyc > 0, 1);

    drain(0, 0, 0, 0);
    check("zero_done_cyc", done_cyc, 1);
    check("zero_reads", rd_cnt, 0);
    check("zero_outputs", hs_d.size(), 0);
    check("zero_busy", busy_bad, 0);

    e.delete();
    for (int i = 0; i < D; i++) begin bram[i] = i + 1; e.push_back(i + 1); end
    drain(D + 5, 0, 0, 0);
    check_out("clamp");
    check("clamp_reads", rd_cnt, D);
    check("clamp_last_addr", last_addr, D - 1);
    check("clamp_done_cyc", done_cyc, D + 3);

    @(posedge clk); #1;
    start = 1; num_rows = 5'd20; shift = '0; relu_en = 0; out_ready = 1;
    @(posedge clk); #1 start = 0;
    repeat (5) @(posedge clk);
    #1 rst = 0;
    #1;
    check("mid_busy", busy, 0); check("mid_done", done, 0); check("mid_rd_en", rd_en, 0);
    check("mid_rd_addr", rd_addr, 0); check("mid_valid", out_valid, 0); check("mid_data", out_data, 0);
    check("mid_index", out_index, 0); check("mid_last", out_last, 0);
    dseen = 0;
    repeat (2) @(negedge clk) if (done) dseen++;
    rst = 1;
    repeat (2) @(negedge clk) if (done) dseen++;
    check("mid_no_done", dseen, 0);
    drain(3, 0, 0, 0);
    e = '{1, 2, 3};
    check_out("after_rst");
    check("after_rst_done_cyc", done_cyc, 6);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", npass, nchk);
    $fatal(1);
  end
endmodule

// File: doc/res_drain.md
# res_drain

Result drain engine that reads signed accumulator entries out of the GEMV result BRAM and streams them out as quantized int8 values. It sits between the result BRAM's read port and the output writeback path. It issues sequential BRAM reads, absorbs the one-cycle read latency and downstream backpressure with a 2-entry buffer, and applies rounding shift, optional ReLU and saturation.

## Interface
- DATA_WIDTH, 32, accumulator width (matches result BRAM word)
- DEPTH, accelerator_config_pkg::MAX_ROWS, BRAM entries
- ADDR_WIDTH, $clog2(DEPTH), BRAM address width
- OUT_WIDTH, 8, signed output width
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse, begins a drain; ignored while busy
- num_rows  in  ADDR_WIDTH+1  entries to drain, sampled on start; values above DEPTH clamp to DEPTH
- shift  in  5  right-shift amount, sampled on start
- relu_en  in  1  clamp negatives to 0, sampled on start
- busy  out  1  high from the cycle after start through the done cycle
- done  out  1  one-cycle pulse at end of drain
- rd_en  out  1  BRAM read enable
- rd_addr  out  ADDR_WIDTH  BRAM read address
- rd_data  in  DATA_WIDTH  signed BRAM data, valid the cycle after rd_en
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream accept
- out_data  out  OUT_WIDTH  signed quantized value
- out_index  out  ADDR_WIDTH  row index of out_data
- out_last  out  1  marks the final element

## Operation
- States: IDLE, RUN, FIN.
- IDLE to RUN on start with num_rows>0. IDLE to FIN on start with num_rows==0: no reads, no output.
- RUN to FIN in the cycle the last element handshakes (out_valid & out_ready & out_last). FIN to IDLE after one cycle.
- Reads are issued in order, addresses 0..num_rows-1, one read per cycle maximum.
- Read issue rule: issue when issued<num_rows and (fifo_count + inflight - pop) < 2. Here pop means a handshake in the current cycle. The buffer never overflows and sustains 1 element/cycle with out_ready held high.
- Capture: the cycle after rd_en, rd_data is quantized and pushed into the 2-entry FIFO together with its index and last flag. out_* is driven from the FIFO head.
- Quantize step 1: compute in DATA_WIDTH+1 bits.
- Quantize step 2: if shift>0, v=(acc + (1<<(shift-1))) >>> shift (round half up). Otherwise v=acc.
- Quantize step 3: if relu_en and v<0, v=0.
- Quantize step 4: saturate to [-128, 127].
- out_data, out_index and out_last hold stable while out_valid & !out_ready.
- A start pulse arriving in RUN or FIN is ignored and does not alter the latched parameters.
- rst asserted mid-drain: all state is cleared immediately. Pending BRAM data is discarded. The block returns to IDLE with no done pulse.

## Timing
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0. FIFO is empty and all counters are 0.
- start at cycle 0 gives:
  - rd_en=1 with rd_addr=0 at cycle 1.
  - rd_data sampled at cycle 2.
  - out_valid=1 with index 0 at cycle 3.
- With out_ready=1 throughout, N rows stream on cycles 3..N+2. done pulses at cycle N+3. busy is high on cycles 1..N+3.
- For num_rows==0, busy and done are both high at cycle 1 only.
- Back-to-back: a start pulse is accepted in the cycle after done.
- rd_en is never asserted when the read result could not be buffered.

## Test plan
- Basic drain: BRAM holds 0..7, num_rows=8, shift=0, relu_en=0, out_ready=1 -> out_data 0..7 on consecutive cycles 3..10, out_last on index 7, done at cycle 11.
- Rounding and saturation: entries {5,-5,1000,-1000,6}, shift=1 -> out_data {3,-2,127,-128,3}.
- ReLU: entries {-3,4}, shift=0, relu_en=1 -> out_data {0,4}.
- Backpressure: 16 rows with out_ready toggling 1,0,0,1 in a pattern -> every index 0..15 delivered exactly once in order, out_data held stable while stalled, and no more than 2 reads outstanding beyond the head.
- Boundaries: num_rows=0 -> done at cycle 1 with no rd_en or out_valid. num_rows=DEPTH+5 -> exactly DEPTH outputs, last rd_addr=DEPTH-1.
- Reset mid-drain: rst low at cycle 6 of a 20-row drain -> all outputs return to their reset values asynchronously, with no done pulse. A new start after reset release drains from index 0.
